// File: rtl/running_light_monitor.sv
// Receive-side checker for a four-LED running light: samples the LEDs after each
// listen_clk step, tracks the walking position and reports lock, stalls and errors.
module running_light_monitor #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 75_000_000,
    parameter int DIR         = 0,
    parameter int LOCK_N      = 2,
    parameter int ERR_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             listen_clk,
    input  logic [3:0]       led_in,
    output logic [1:0]       pos,
    output logic             pos_valid,
    output logic             locked,
    output logic             stalled,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Counter holds cycles since the rise minus one; it "reaches" the limit when its
    // incremented value equals TIMEOUT_CYC-1 (TIMEOUT_CYC is expected to be >= 2).
    localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       SETTLE    = 4'(SETTLE_CYC);
    localparam logic [2:0]       LOCK_GOOD = 3'(LOCK_N);
    localparam logic [ERR_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] ERR_STEP  = 2'b01;
    localparam logic [1:0] ERR_1HOT  = 2'b10;
    localparam logic [1:0] ERR_STALL = 2'b11;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       good_reg, good_next;
    logic             lc_q_reg;
    logic [3:0]       settle_cnt_reg, settle_cnt_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic [1:0]       pos_reg, pos_next;
    logic             pos_valid_reg, pos_valid_next;
    logic             locked_reg;
    logic             stalled_reg, stalled_next;
    logic             err_pulse_reg, err_pulse_next;
    logic [1:0]       err_code_reg, err_code_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    logic             rise;
    logic             sample;
    logic             stall_hit;
    logic [TO_W-1:0]  to_inc;
    logic [3:0]       single;
    logic             ok1h;
    logic [1:0]       pos_s;
    logic [1:0]       nxt;
    logic             match;
    logic [2:0]       good_inc;
    logic             err_event;

    assign rise = listen_clk & ~lc_q_reg;

    // One comparator per LED: led_in must equal exactly that single bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign single[gi] = (led_in == (4'b0001 << gi));
        end
    endgenerate

    assign ok1h  = |single;
    assign pos_s = {single[3] | single[2], single[3] | single[1]};
    assign nxt   = (DIR != 0) ? pos_reg - 2'd1 : pos_reg + 2'd1;
    assign match = ok1h && (pos_s == nxt);

    // A rise landing on the sample cycle restarts the window, so the old sample is dropped.
    assign sample = !rise && (settle_cnt_reg == 4'd1);

    always_comb begin
        settle_cnt_next = settle_cnt_reg;
        if (rise) begin
            settle_cnt_next = SETTLE;
        end else if (settle_cnt_reg != 4'd0) begin
            settle_cnt_next = settle_cnt_reg - 4'd1;
        end
    end

    assign to_inc    = to_cnt_reg + TO_W'(1);
    assign stall_hit = !rise && (to_inc == TO_LIM);

    always_comb begin
        to_cnt_next = to_inc;
        if (rise || stall_hit) begin
            to_cnt_next = '0;
        end
    end

    assign good_inc = good_reg + 3'd1;

    always_comb begin
        state_next     = state_reg;
        good_next      = good_reg;
        pos_next       = pos_reg;
        pos_valid_next = 1'b0;
        stalled_next   = stalled_reg;
        err_event      = 1'b0;
        err_code_next  = err_code_reg;

        if (rise) begin
            stalled_next = 1'b0;
        end

        // Stall outranks a coinciding sample; that sample is discarded entirely.
        if (stall_hit) begin
            stalled_next = 1'b1;
            if (!stalled_reg && state_reg != HUNT) begin
                state_next    = HUNT;
                good_next     = 3'd0;
                err_event     = 1'b1;
                err_code_next = ERR_STALL;
            end
        end else if (sample) begin
            if (ok1h) begin
                pos_next       = pos_s;
                pos_valid_next = 1'b1;
            end
            case (state_reg)
                HUNT: begin
                    if (ok1h) begin
                        state_next = TRACK;
                        good_next  = 3'd1;
                    end
                end
                TRACK: begin
                    if (match) begin
                        good_next = good_inc;
                        if (good_inc == LOCK_GOOD) begin
                            state_next = LOCKED;
                        end
                    end else if (ok1h) begin
                        good_next     = 3'd1;
                        err_event     = 1'b1;
                        err_code_next = ERR_STEP;
                    end else begin
                        state_next    = HUNT;
                        good_next     = 3'd0;
                        err_event     = 1'b1;
                        err_code_next = ERR_1HOT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        state_next = LOCKED;
                    end else if (ok1h) begin
                        state_next    = TRACK;
                        good_next     = 3'd1;
                        err_event     = 1'b1;
                        err_code_next = ERR_STEP;
                    end else begin
                        state_next    = HUNT;
                        good_next     = 3'd0;
                        err_event     = 1'b1;
                        err_code_next = ERR_1HOT;
                    end
                end
                default: begin
                    state_next = HUNT;
                    good_next  = 3'd0;
                end
            endcase
        end

        err_pulse_next = err_event;
        err_cnt_next   = err_cnt_reg;
        if (err_event && err_cnt_reg != CNT_MAX) begin
            err_cnt_next = err_cnt_reg + ERR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        // Loading lc_q during reset keeps a high listen_clk at release from looking like a rise.
        lc_q_reg <= listen_clk;
        if (sys_rst) begin
            state_reg      <= HUNT;
            good_reg       <= 3'd0;
            settle_cnt_reg <= 4'd0;
            to_cnt_reg     <= '0;
            pos_reg        <= 2'd0;
            pos_valid_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            stalled_reg    <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_code_reg   <= 2'd0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            good_reg       <= good_next;
            settle_cnt_reg <= settle_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            pos_reg        <= pos_next;
            pos_valid_reg  <= pos_valid_next;
            locked_reg     <= (state_next == LOCKED);
            stalled_reg    <= stalled_next;
            err_pulse_reg  <= err_pulse_next;
            err_code_reg   <= err_code_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign pos       = pos_reg;
    assign pos_valid = pos_valid_reg;
    assign locked    = locked_reg;
    assign stalled   = stalled_reg;
    assign err_pulse = err_pulse_reg;
    assign err_code  = err_code_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
